// File: rtl/y86_mem_pkg.sv
// Shared constants and types for the Y86 data-memory path.
package y86_mem_pkg;

  localparam int DEPTH = 8192;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } owner_t;

endpackage

// File: rtl/y86_dmem_arbiter.sv
// Single-port data RAM arbiter between the Y86 fetch and memory stages.
// Handshake: a requester holds req/addr/we/wdata until its gnt is high; rvalid follows one cycle after a read grant.
module y86_dmem_arbiter
  import y86_mem_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [63:0]   i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [63:0]   i_rdata,
  output logic          i_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [63:0]   d_addr,
  input  logic [63:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [63:0]   d_rdata,
  output logic          d_err,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [63:0]   ram_wdata,
  input  logic [63:0]   ram_rdata
);

  localparam int WCW = $clog2(MAX_WAIT + 1);

  logic [WCW-1:0] wait_cnt;
  owner_t         owner_q;
  logic           err_q;
  logic           we_q;
  logic [63:0]    i_hold_q;
  logic [63:0]    d_hold_q;
  logic [63:0]    sel_addr;
  logic           addr_err;
  logic           any_gnt;

  // Fetch wins a conflict only once it has been denied MAX_WAIT cycles in a row.
  always_comb begin
    i_gnt    = i_req && (!d_req || (wait_cnt == WCW'(MAX_WAIT)));
    d_gnt    = d_req && !i_gnt;
    any_gnt  = i_gnt || d_gnt;
    sel_addr = i_gnt ? i_addr : d_addr;
    // Full-width compare so high address bits can never alias into the array.
    addr_err = (sel_addr >= 64'(DEPTH));
    ram_en   = any_gnt && !addr_err;
    ram_we   = d_gnt && d_we && !addr_err;
    ram_addr = sel_addr[AW-1:0];
    ram_wdata = d_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (i_req && !i_gnt) begin
      if (wait_cnt != WCW'(MAX_WAIT)) wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= NONE;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      owner_q <= i_gnt ? FETCH : (d_gnt ? DATA : NONE);
      err_q   <= any_gnt && addr_err;
      we_q    <= d_gnt && d_we;
    end
  end

  always_comb begin
    i_rvalid = (owner_q == FETCH);
    i_err    = (owner_q == FETCH) && err_q;
    d_rvalid = (owner_q == DATA) && !we_q;
    d_err    = (owner_q == DATA) && err_q;
    i_rdata  = i_hold_q;
    d_rdata  = d_hold_q;
    if (i_rvalid) i_rdata = err_q ? 64'd0 : ram_rdata;
    if (d_rvalid) d_rdata = err_q ? 64'd0 : ram_rdata;
  end

  // Idle ports keep showing their last returned word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_hold_q <= '0;
      d_hold_q <= '0;
    end else begin
      if (i_rvalid) i_hold_q <= i_rdata;
      if (d_rvalid) d_hold_q <= d_rdata;
    end
  end

endmodule

// File: tb/tb_y86_dmem_arbiter.sv
// Directed bench for y86_dmem_arbiter with a behavioural single-port RAM.
module tb_y86_dmem_arbiter;
  import y86_mem_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req;
  logic [63:0]   i_addr;
  logic          i_gnt, i_rvalid, i_err;
  logic [63:0]   i_rdata;
  logic          d_req, d_we;
  logic [63:0]   d_addr, d_wdata;
  logic          d_gnt, d_rvalid, d_err;
  logic [63:0]   d_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [63:0]   ram_wdata;
  logic [63:0]   ram_rdata = 64'd0;

  logic [63:0]   mem [0:DEPTH-1];

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [63:0] A0   = 64'h0A0A_0000_0000_0A00;
  localparam logic [63:0] A8   = 64'h0A0A_0000_0000_0A08;
  localparam logic [63:0] C100 = 64'hC0C0_0000_0000_0100;

  // clock / reset
  always #5 clk = ~clk;

  y86_dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_d(input logic we, input logic [63:0] addr, input logic [63:0] wdata);
    d_req   = 1'b1;
    d_we    = we;
    d_addr  = addr;
    d_wdata = wdata;
  endtask

  task automatic drive_i(input logic [63:0] addr);
    i_req  = 1'b1;
    i_addr = addr;
  endtask

  task automatic idle();
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) mem[k] = 64'd0;
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_i_rvalid", i_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_i_err", i_err, 0);
    chk("rst_d_err", d_err, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_wait_cnt", dut.wait_cnt, 0);

    // data write then read of 0x10
    drive_d(1'b1, 64'h10, 64'hDEAD_BEEF);
    #1;
    chk("wr_d_gnt", d_gnt, 1);
    chk("wr_i_gnt", i_gnt, 0);
    chk("wr_ram_en", ram_en, 1);
    chk("wr_ram_we", ram_we, 1);
    chk("wr_ram_addr", ram_addr, 64'h10);
    cyc();
    chk("wr_no_rvalid", d_rvalid, 0);
    chk("wr_no_err", d_err, 0);
    drive_d(1'b0, 64'h10, 64'd0);
    #1;
    chk("rd_d_gnt", d_gnt, 1);
    chk("rd_ram_we", ram_we, 0);
    cyc();
    chk("rd_d_rvalid", d_rvalid, 1);
    chk("rd_d_rdata", d_rdata, 64'hDEAD_BEEF);
    chk("rd_d_err", d_err, 0);

    // last legal address
    drive_d(1'b1, 64'd8191, 64'h55);
    #1;
    chk("edge_ram_en", ram_en, 1);
    chk("edge_ram_addr", ram_addr, 64'h1FFF);
    cyc();
    drive_d(1'b0, 64'd8191, 64'd0);
    cyc();
    chk("edge_d_rvalid", d_rvalid, 1);
    chk("edge_d_rdata", d_rdata, 64'h55);
    chk("edge_d_err", d_err, 0);

    // out-of-range write must not alias onto address 0
    drive_d(1'b1, 64'd0, 64'h1234);
    cyc();
    drive_d(1'b1, 64'd8192, 64'h77);
    #1;
    chk("oor_wr_d_gnt", d_gnt, 1);
    chk("oor_wr_ram_en", ram_en, 0);
    chk("oor_wr_ram_we", ram_we, 0);
    cyc();
    chk("oor_wr_d_err", d_err, 1);
    chk("oor_wr_d_rvalid", d_rvalid, 0);
    chk("oor_wr_d_rdata_hold", d_rdata, 64'h55);
    drive_d(1'b0, 64'd0, 64'd0);
    cyc();
    chk("oor_rd0_rvalid", d_rvalid, 1);
    chk("oor_rd0_rdata", d_rdata, 64'h1234);
    chk("oor_rd0_err", d_err, 0);
    drive_d(1'b0, 64'd8192, 64'd0);
    cyc();
    chk("oor_rd_rvalid", d_rvalid, 1);
    chk("oor_rd_err", d_err, 1);
    chk("oor_rd_rdata", d_rdata, 0);

    // fetch of all-ones address
    idle();
    drive_i(64'hFFFF_FFFF_FFFF_FFFF);
    #1;
    chk("oor_f_i_gnt", i_gnt, 1);
    chk("oor_f_ram_en", ram_en, 0);
    cyc();
    chk("oor_f_i_rvalid", i_rvalid, 1);
    chk("oor_f_i_err", i_err, 1);
    chk("oor_f_i_rdata", i_rdata, 0);
    chk("oor_f_d_err", d_err, 0);

    // preload for conflict and back-to-back
    idle();
    drive_d(1'b1, 64'h0, A0);
    cyc();
    drive_d(1'b1, 64'h8, A8);
    cyc();
    drive_d(1'b1, 64'h100, C100);
    cyc();

    // conflict: fetch held, 8 data reads; fetch wins on the fifth cycle
    drive_d(1'b0, 64'h100, 64'd0);
    drive_i(64'h0);
    for (int c = 0; c < 9; c++) begin
      #1;
      chk($sformatf("cf_i_gnt_%0d", c), i_gnt, (c == 4) ? 1 : 0);
      chk($sformatf("cf_d_gnt_%0d", c), d_gnt, (c == 4) ? 0 : 1);
      chk($sformatf("cf_wait_%0d", c), dut.wait_cnt, (c <= 4) ? c : 0);
      cyc();
      if (c == 4) begin
        chk("cf_i_rvalid", i_rvalid, 1);
        chk("cf_i_rdata", i_rdata, A0);
        chk("cf_d_quiet", d_rvalid, 0);
        i_req = 1'b0;
      end else begin
        chk($sformatf("cf_d_rdata_%0d", c), d_rdata, C100);
      end
    end
    idle();
    #1;
    chk("cf_wait_end", dut.wait_cnt, 0);

    // back-to-back alternating owners
    drive_i(64'h0);
    cyc();
    chk("bb_f0_rvalid", i_rvalid, 1);
    chk("bb_f0_rdata", i_rdata, A0);
    chk("bb_f0_d_quiet", d_rvalid, 0);
    idle();
    drive_d(1'b0, 64'h100, 64'd0);
    cyc();
    chk("bb_d_rvalid", d_rvalid, 1);
    chk("bb_d_rdata", d_rdata, C100);
    chk("bb_d_i_quiet", i_rvalid, 0);
    chk("bb_i_hold", i_rdata, A0);
    idle();
    drive_i(64'h8);
    cyc();
    chk("bb_f8_rvalid", i_rvalid, 1);
    chk("bb_f8_rdata", i_rdata, A8);
    chk("bb_f8_d_quiet", d_rvalid, 0);
    chk("bb_d_hold", d_rdata, C100);

    // async reset while a fetch response is pending
    #2 rst = 1'b1;
    idle();
    #1;
    chk("ar_i_rvalid", i_rvalid, 0);
    chk("ar_i_rdata", i_rdata, 0);
    chk("ar_d_rdata", d_rdata, 0);
    chk("ar_i_err", i_err, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc();
    chk("ar_post_i_rvalid", i_rvalid, 0);
    chk("ar_post_d_rvalid", d_rvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/y86_dmem_arbiter.md
# y86_dmem_arbiter

Arbitrates a single-ported 8192-entry × 64-bit data RAM between the fetch-stage instruction port and the memory-stage data port of the pipelined Y86 processor. It sits between the Fetch and Memory pipeline stages and the RAM array:
- Issues at most one RAM access per cycle.
- Returns read data to the owning requester one cycle later.
- Flags out-of-range addresses as memory errors (stat code 3).
- Prevents the fetch port from starving.

## Interface
- DEPTH, 8192, RAM entries; a legal address is `addr < DEPTH`.
- AW, 13, RAM address width, `$clog2(DEPTH)`.
- MAX_WAIT, 4, consecutive denied fetch cycles before fetch wins the next conflict.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- i_req  in  1  fetch read request.
- i_addr  in  64  fetch address.
- i_gnt  out  1  fetch granted this cycle (combinational); low means Fetch must stall.
- i_rvalid  out  1  fetch response valid.
- i_rdata  out  64  fetch read data.
- i_err  out  1  fetch address was out of range (pulses with i_rvalid).
- d_req  in  1  memory-stage request.
- d_we  in  1  1 = write (rmmovq/call/pushq), 0 = read (mrmovq/ret/popq).
- d_addr  in  64  data address.
- d_wdata  in  64  write data.
- d_gnt  out  1  data port granted this cycle (combinational).
- d_rvalid  out  1  data read response valid (reads only).
- d_rdata  out  64  data read data.
- d_err  out  1  data address out of range (reads and writes).
- ram_en  out  1  RAM access strobe (combinational).
- ram_we  out  1  RAM write strobe (combinational).
- ram_addr  out  AW  RAM address.
- ram_wdata  out  64  RAM write data.
- ram_rdata  in  64  RAM read data; valid the cycle after ram_en with ram_we=0.

## Operation
**Arbitration (combinational, each cycle)**
- Only d_req: d_gnt=1.
- Only i_req: i_gnt=1.
- Both requesting: d_gnt=1, unless `wait_cnt == MAX_WAIT`, in which case i_gnt=1.
- i_gnt and d_gnt are never both high.

**Access**
- The granted address is in range: ram_en=1, ram_addr = addr[AW-1:0], ram_we = d_we for the data port (0 for fetch).
- The granted address is ≥ DEPTH: ram_en=0, so no RAM access and no write occurs. The error is still reported.

**Starvation counter (wait_cnt)**
- Increments when i_req=1 and i_gnt=0, saturating at MAX_WAIT.
- Clears to 0 on an i_gnt cycle or when i_req=0.

**Response register** (owner ∈ {NONE, FETCH, DATA}, plus err_q and we_q), loaded every cycle from the current grant.
- Fetch grant: i_rvalid=1 next cycle, i_rdata = ram_rdata, i_err = err_q.
- Data read grant: d_rvalid=1 next cycle, d_rdata = ram_rdata.
- Data write grant: d_rvalid stays 0.
- d_err = err_q for either data operation.
- On any error: rdata is forced to 0.
- When a port does not have rvalid, its rdata holds its last value.

## Timing
- Grant: same cycle as the request, combinational.
- Read latency: 1 cycle after the grant.
- Writes: commit at the grant-cycle clock edge.
- Throughput: back-to-back grants are allowed every cycle, because a response phase overlaps the next grant.
- A requester holds req, addr, we and wdata stable until it sees its gnt.
- A request dropped before gnt is simply abandoned; no state is kept.
- Reset values (all outputs and state): i_rvalid, d_rvalid, i_err, d_err = 0; i_rdata, d_rdata = 0; owner = NONE; wait_cnt = 0.
- Asserting rst mid-operation discards any pending response: no rvalid is issued after reset deasserts.
- Address boundaries:
  - addr = 8191 is legal.
  - addr = 8192 is an error.
  - Only the full 64-bit compare decides legality; the upper bits are never truncated before the check.

## Structure
- Shared package `y86_mem_pkg`:
  - DEPTH and AW constants.
  - Stat codes STAT_AOK=1, STAT_HLT=2, STAT_ADR=3, STAT_INS=4.
  - owner_t enum (NONE, FETCH, DATA).
- Single module with no sub-module. The starvation counter and the response register are small enough to live inline.

## Test plan
- **Reset:** assert rst asynchronously mid-cycle with a pending fetch read → all outputs are 0 immediately and no i_rvalid follows.
- **Data write then read:** d_we=1, d_addr=0x10, d_wdata=0xDEAD_BEEF, then a read of 0x10 → d_gnt each cycle, d_rvalid one cycle after the read grant with d_rdata=0xDEAD_BEEF, d_err=0.
- **Conflict:** i_req and d_req held high together with the data port issuing 8 reads → data granted 4 times, fetch granted on cycle 5, data resumes, wait_cnt returns to 0.
- **Out-of-range:** a data write to 8192 → ram_en=0, d_err=1 next cycle, and a subsequent read of 0 shows no corruption. A fetch of 0xFFFF_FFFF_FFFF_FFFF → i_rvalid=1, i_err=1, i_rdata=0.
- **Edge address:** d_addr=8191 write 0x55 / read → d_rdata=0x55, d_err=0.
- **Back-to-back:** alternating fetch reads of 0x0, 0x8 and data reads of 0x100 on consecutive cycles → each rvalid arrives exactly 1 cycle after its grant with the correct owner routing.
